// File: rtl/s3g_link_tester.sv
// S3G link exerciser: frames a host-loaded payload, sends it through a UART,
// then checks the reply packet (length, payload, CRC-8/Maxim) within a timeout.
module s3g_link_tester #(
  parameter int MAX_PAYLOAD = 32,
  parameter int TIMEOUT     = 100000,
  parameter int GAP         = 0,
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    tx_len_i,
  input  logic          tx_we_i,
  input  logic [AW-1:0] tx_addr_i,
  input  logic [7:0]    tx_wdata_i,
  input  logic [7:0]    exp_len_i,
  input  logic          exp_we_i,
  input  logic [AW-1:0] exp_addr_i,
  input  logic [7:0]    exp_wdata_i,
  input  logic          start_i,
  output logic [7:0]    uart_tx_data_o,
  output logic          uart_tx_wr_o,
  input  logic          uart_tx_done_i,
  input  logic [7:0]    uart_rx_data_i,
  input  logic          uart_rx_done_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [2:0]    fail_code_o,
  output logic [7:0]    fail_index_o,
  output logic [15:0]   pkt_count_o,
  output logic [15:0]   err_count_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_TX_SOF  = 4'd1;
  localparam logic [3:0] S_TX_LEN  = 4'd2;
  localparam logic [3:0] S_TX_DATA = 4'd3;
  localparam logic [3:0] S_TX_CRC  = 4'd4;
  localparam logic [3:0] S_RX_SOF  = 4'd5;
  localparam logic [3:0] S_RX_LEN  = 4'd6;
  localparam logic [3:0] S_RX_DATA = 4'd7;
  localparam logic [3:0] S_RX_CRC  = 4'd8;
  localparam logic [3:0] S_FINISH  = 4'd9;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  logic [7:0] tx_mem [MAX_PAYLOAD];
  logic [7:0] exp_mem [MAX_PAYLOAD];

  logic [3:0]    state_q, state_d;
  logic [7:0]    tx_len_q, tx_len_d, exp_len_q, exp_len_d;
  logic [7:0]    idx_q, idx_d, crc_q, crc_d;
  logic [TW-1:0] to_q, to_d;
  logic          gap_on_q, gap_on_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]    code_q, code_d, fin_code;
  logic [7:0]    fidx_q, fidx_d;
  logic [15:0]   pkt_q, pkt_d, err_q, err_d;
  logic          fin, fire, tx_wait;
  logic [7:0]    tx_rd, exp_rd;

  // RAMs are written regardless of state; no reset on contents
  always_ff @(posedge clk_i) begin
    if (tx_we_i)  tx_mem[tx_addr_i]   <= tx_wdata_i;
    if (exp_we_i) exp_mem[exp_addr_i] <= exp_wdata_i;
  end

  assign tx_rd   = tx_mem[idx_q[AW-1:0]];
  assign exp_rd  = exp_mem[idx_q[AW-1:0]];
  assign tx_wait = (state_q == S_TX_SOF) || (state_q == S_TX_LEN) || (state_q == S_TX_DATA);
  // next byte goes out GAP+1 cycles after the transmitter reports done
  assign fire    = (GAP == 0) ? uart_tx_done_i : (gap_on_q && gap_q == GW'(1));

  always_comb begin
    state_d = state_q;  tx_len_d = tx_len_q;  exp_len_d = exp_len_q;
    idx_d = idx_q;  crc_d = crc_q;  to_d = to_q;
    gap_on_d = gap_on_q;  gap_d = gap_q;
    tx_data_d = tx_data_q;  tx_wr_d = 1'b0;
    busy_d = busy_q;  done_d = 1'b0;  pass_d = pass_q;
    code_d = code_q;  fidx_d = fidx_q;  pkt_d = pkt_q;  err_d = err_q;
    fin = 1'b0;  fin_code = code_q;

    if (gap_on_q) begin
      if (gap_q == GW'(1)) gap_on_d = 1'b0;
      else gap_d = gap_q - GW'(1);
    end
    if (GAP != 0 && tx_wait && uart_tx_done_i) begin
      gap_on_d = 1'b1;
      gap_d    = GW'(GAP);
    end

    case (state_q)
      S_IDLE: if (start_i) begin
        busy_d = 1'b1;  pass_d = 1'b0;  code_d = 3'd0;  crc_d = 8'h00;
        tx_len_d = tx_len_i;  exp_len_d = exp_len_i;
        if (tx_len_i == 8'd0 || int'(tx_len_i) > MAX_PAYLOAD ||
            exp_len_i == 8'd0 || int'(exp_len_i) > MAX_PAYLOAD) begin
          fin = 1'b1;  fin_code = 3'd5;
        end else begin
          tx_wr_d = 1'b1;  tx_data_d = 8'hD5;  state_d = S_TX_SOF;
        end
      end
      S_TX_SOF: if (fire) begin
        tx_wr_d = 1'b1;  tx_data_d = tx_len_q;  idx_d = 8'd0;  state_d = S_TX_LEN;
      end
      S_TX_LEN, S_TX_DATA: if (fire) begin
        tx_wr_d = 1'b1;
        if (state_q == S_TX_DATA && idx_q == tx_len_q) begin
          tx_data_d = crc_q;  state_d = S_TX_CRC;
        end else begin
          tx_data_d = tx_rd;  crc_d = crc8_step(crc_q, tx_rd);
          idx_d = idx_q + 8'd1;  state_d = S_TX_DATA;
        end
      end
      S_TX_CRC: if (uart_tx_done_i) begin
        state_d = S_RX_SOF;  to_d = '0;  crc_d = 8'h00;
      end
      S_RX_SOF, S_RX_LEN, S_RX_DATA, S_RX_CRC: begin
        if (uart_rx_done_i) begin
          to_d = '0;
          if (state_q == S_RX_SOF) begin
            if (uart_rx_data_i == 8'hD5) state_d = S_RX_LEN;
          end else if (state_q == S_RX_LEN) begin
            if (uart_rx_data_i != exp_len_q) begin
              fin = 1'b1;  fin_code = 3'd2;
            end else begin
              idx_d = 8'd0;  crc_d = 8'h00;  state_d = S_RX_DATA;
            end
          end else if (state_q == S_RX_DATA) begin
            crc_d = crc8_step(crc_q, uart_rx_data_i);
            // keep consuming after a mismatch so the CRC byte stays aligned
            if (uart_rx_data_i != exp_rd && code_q == 3'd0) begin
              code_d = 3'd3;  fidx_d = idx_q;
            end
            idx_d = idx_q + 8'd1;
            if (idx_q == exp_len_q - 8'd1) state_d = S_RX_CRC;
          end else begin
            fin = 1'b1;
            fin_code = (code_q == 3'd0 && uart_rx_data_i != crc_q) ? 3'd4 : code_q;
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          fin = 1'b1;  fin_code = 3'd1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_FINISH: begin
        busy_d = 1'b0;  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_FINISH;  done_d = 1'b1;  code_d = fin_code;
      pass_d = (fin_code == 3'd0);  pkt_d = pkt_q + 16'd1;
      if (fin_code != 3'd0) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  tx_len_q <= '0;  exp_len_q <= '0;
      idx_q <= '0;  crc_q <= '0;  to_q <= '0;  gap_on_q <= 1'b0;  gap_q <= '0;
      tx_data_q <= '0;  tx_wr_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
      pass_q <= 1'b0;  code_q <= '0;  fidx_q <= '0;  pkt_q <= '0;  err_q <= '0;
    end else begin
      state_q <= state_d;  tx_len_q <= tx_len_d;  exp_len_q <= exp_len_d;
      idx_q <= idx_d;  crc_q <= crc_d;  to_q <= to_d;  gap_on_q <= gap_on_d;  gap_q <= gap_d;
      tx_data_q <= tx_data_d;  tx_wr_q <= tx_wr_d;  busy_q <= busy_d;  done_q <= done_d;
      pass_q <= pass_d;  code_q <= code_d;  fidx_q <= fidx_d;  pkt_q <= pkt_d;  err_q <= err_d;
    end
  end

  assign uart_tx_data_o = tx_data_q;
  assign uart_tx_wr_o   = tx_wr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_code_o    = code_q;
  assign fail_index_o   = fidx_q;
  assign pkt_count_o    = pkt_q;
  assign err_count_o    = err_q;
endmodule

// File: tb/tb_s3g_link_tester.sv
// Bench for s3g_link_tester: plays the UART transmitter and the remote replier,
// and predicts each outcome by parsing the reply bytes against the expected payload.
module tb_s3g_link_tester;
  localparam int MAXP = 32;
  localparam int TO   = 50;
  localparam int GP   = 2;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tx_len, exp_len, tx_wdata, exp_wdata, rx_data;
  logic          tx_we, exp_we, start, tx_done, rx_done;
  logic [AW-1:0] tx_addr, exp_addr;
  logic [7:0]    tx_data_o, fail_index_o;
  logic          tx_wr_o, busy_o, done_o, pass_o;
  logic [2:0]    fail_code_o;
  logic [15:0]   pkt_count_o, err_count_o;

  always #5 clk = ~clk;

  s3g_link_tester #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TO), .GAP(GP)) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_len_i(tx_len), .tx_we_i(tx_we), .tx_addr_i(tx_addr), .tx_wdata_i(tx_wdata),
    .exp_len_i(exp_len), .exp_we_i(exp_we), .exp_addr_i(exp_addr), .exp_wdata_i(exp_wdata),
    .start_i(start),
    .uart_tx_data_o(tx_data_o), .uart_tx_wr_o(tx_wr_o), .uart_tx_done_i(tx_done),
    .uart_rx_data_i(rx_data), .uart_rx_done_i(rx_done),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_code_o(fail_code_o),
    .fail_index_o(fail_index_o), .pkt_count_o(pkt_count_o), .err_count_o(err_count_o)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;
  int m_pkt = 0, m_err = 0;
  logic [7:0] tx_pl[$], exp_pl[$], reply_q[$];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  // Outcome of a reply: code, first bad index, and reply index that ends it (-1 = timeout)
  task automatic model(input int el, output int code, output int fidx, output int last);
    int p;
    logic [7:0] c;
    code = 1;  fidx = 0;  last = -1;  p = -1;
    for (int i = reply_q.size() - 1; i >= 0; i--) if (reply_q[i] == 8'hD5) p = i;
    if (p < 0 || p + 1 >= reply_q.size()) return;
    if (int'(reply_q[p+1]) != el) begin code = 2;  last = p + 1;  return; end
    if (p + 2 + el >= reply_q.size()) return;
    c = 8'h00;  code = 0;
    for (int i = 0; i < el; i++) begin
      c = crc8(c, reply_q[p+2+i]);
      if (code == 0 && reply_q[p+2+i] != exp_pl[i]) begin code = 3;  fidx = i; end
    end
    if (code == 0 && c != reply_q[p+2+el]) code = 4;
    last = p + 2 + el;
  endtask

  task automatic run_txn(input int tl, input int el, input bit noise);
    logic [7:0] stream[$];
    logic [7:0] c;
    int code, fidx, last, nsend, n;
    bit legal;
    foreach (tx_pl[i]) begin
      tx_we = 1'b1;  tx_addr = AW'(i);  tx_wdata = tx_pl[i];  cyc();
    end
    tx_we = 1'b0;
    foreach (exp_pl[i]) begin
      exp_we = 1'b1;  exp_addr = AW'(i);  exp_wdata = exp_pl[i];  cyc();
    end
    exp_we = 1'b0;
    legal = tl >= 1 && tl <= MAXP && el >= 1 && el <= MAXP;
    stream = '{8'hD5, 8'(tl)};
    c = 8'h00;
    for (int i = 0; i < tl && legal; i++) begin
      stream.push_back(tx_pl[i]);  c = crc8(c, tx_pl[i]);
    end
    stream.push_back(c);
    tx_len = 8'(tl);  exp_len = 8'(el);  start = 1'b1;  cyc();  start = 1'b0;
    chk("busy_rise", busy_o, !legal ? 1 : 1);
    if (!legal) begin
      m_pkt++;  m_err++;
      chk("bad_param_wr", tx_wr_o, 0);
      chk("bad_param_done", done_o, 1);
      chk("bad_param_code", fail_code_o, 5);
      chk("bad_param_pass", pass_o, 0);
      chk("bad_param_err", err_count_o, 32'(m_err));
      repeat (4) begin cyc();  chk("bad_param_nowr", tx_wr_o, 0); end
      chk("bad_param_idle", busy_o, 0);
      return;
    end
    foreach (stream[k]) begin
      chk("tx_wr", tx_wr_o, 1);
      chk("tx_byte", tx_data_o, stream[k]);
      repeat ($urandom_range(1, 4)) begin
        if (noise) begin
          rx_data = $urandom_range(0, 1) ? 8'hD5 : 8'($urandom);
          rx_done = 1'b1;  start = 1'b1;
        end
        cyc();
        rx_done = 1'b0;  start = 1'b0;
        chk("tx_wr_pulse", tx_wr_o, 0);
      end
      tx_done = 1'b1;  cyc();  tx_done = 1'b0;
      if (k != stream.size() - 1)
        repeat (GP) begin chk("tx_gap", tx_wr_o, 0);  cyc(); end
    end
    model(el, code, fidx, last);
    nsend = (last < 0) ? reply_q.size() : last + 1;
    for (int j = 0; j < nsend; j++) begin
      repeat ($urandom_range(0, 3)) cyc();
      rx_data = reply_q[j];  rx_done = 1'b1;  cyc();  rx_done = 1'b0;
    end
    n = 1;
    while (done_o !== 1'b1 && n < TO + 20) begin cyc();  n++; end
    chk("done_latency", n, (last < 0) ? TO + 1 : 1);
    m_pkt++;
    if (code != 0) m_err++;
    chk("pass", pass_o, (code == 0) ? 1 : 0);
    chk("fail_code", fail_code_o, 32'(code));
    if (code == 3) chk("fail_index", fail_index_o, 32'(fidx));
    chk("pkt_count", pkt_count_o, 32'(m_pkt & 16'hFFFF));
    chk("err_count", err_count_o, 32'(m_err & 16'hFFFF));
    cyc();
    chk("done_pulse", done_o, 0);
    chk("busy_fall", busy_o, 0);
  endtask

  initial begin
    int tl, el, mode, cut;
    logic [7:0] pl[$];
    logic [7:0] c;
    rst = 1'b1;  start = 1'b0;  tx_we = 1'b0;  exp_we = 1'b0;  tx_done = 1'b0;  rx_done = 1'b0;
    tx_len = '0;  exp_len = '0;  tx_addr = '0;  exp_addr = '0;  tx_wdata = '0;  exp_wdata = '0;
    rx_data = '0;
    repeat (3) cyc();
    chk("rst_wr", tx_wr_o, 0);        chk("rst_data", tx_data_o, 0);
    chk("rst_busy", busy_o, 0);       chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);       chk("rst_code", fail_code_o, 0);
    chk("rst_fidx", fail_index_o, 0); chk("rst_pkt", pkt_count_o, 0);
    chk("rst_err", err_count_o, 0);
    rst = 1'b0;  cyc();

    tx_pl = '{8'h00};  exp_pl = '{8'h85};
    reply_q = '{8'hD5, 8'h01, 8'h85, 8'hB3};
    run_txn(1, 1, 1'b0);
    chk("t1_pass", pass_o, 1);  chk("t1_pkt", pkt_count_o, 1);
    reply_q = '{8'hD5, 8'h01, 8'h85, 8'hB4};
    run_txn(1, 1, 1'b0);
    chk("t2_code", fail_code_o, 4);  chk("t2_err", err_count_o, 1);
    reply_q = '{8'hFF, 8'h12, 8'hD5, 8'h01, 8'h85, 8'hB3};
    run_txn(1, 1, 1'b1);
    chk("t3_resync", pass_o, 1);
    exp_pl = '{8'h86};
    reply_q = '{8'hD5, 8'h01, 8'h85, 8'hB3};
    run_txn(1, 1, 1'b0);
    chk("t4_code", fail_code_o, 3);  chk("t4_fidx", fail_index_o, 0);
    reply_q = '{8'hD5, 8'h02};
    run_txn(1, 1, 1'b0);
    chk("t5_code", fail_code_o, 2);
    reply_q.delete();
    run_txn(1, 1, 1'b0);
    chk("t6_code", fail_code_o, 1);
    run_txn(0, 1, 1'b0);

    // reset while waiting for the transmitter to finish a payload byte
    tx_pl = '{8'h11, 8'h22, 8'h33};
    foreach (tx_pl[i]) begin tx_we = 1'b1;  tx_addr = AW'(i);  tx_wdata = tx_pl[i];  cyc(); end
    tx_we = 1'b0;
    tx_len = 8'd3;  exp_len = 8'd3;  start = 1'b1;  cyc();  start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_seq_wr", tx_wr_o, 1);
      cyc();
      if (k < 2) begin
        tx_done = 1'b1;  cyc();  tx_done = 1'b0;
        repeat (GP) cyc();
      end
    end
    rst = 1'b1;  cyc();  rst = 1'b0;
    chk("abort_wr", tx_wr_o, 0);     chk("abort_data", tx_data_o, 0);
    chk("abort_busy", busy_o, 0);    chk("abort_done", done_o, 0);
    chk("abort_pass", pass_o, 0);    chk("abort_code", fail_code_o, 0);
    chk("abort_pkt", pkt_count_o, 0); chk("abort_err", err_count_o, 0);
    tx_done = 1'b1;  cyc();  tx_done = 1'b0;
    repeat (GP + 4) begin chk("abort_nowr", tx_wr_o, 0);  cyc(); end
    m_pkt = 0;  m_err = 0;

    for (int t = 0; t < 25; t++) begin
      tl = $urandom_range(1, MAXP);
      el = $urandom_range(1, MAXP);
      mode = $urandom_range(0, 5);
      tx_pl.delete();  exp_pl.delete();  reply_q.delete();  pl.delete();
      for (int i = 0; i < tl; i++) tx_pl.push_back(8'($urandom));
      for (int i = 0; i < el; i++) exp_pl.push_back(8'($urandom));
      if (mode == 4) repeat ($urandom_range(1, 3)) reply_q.push_back(8'($urandom_range(0, 8'hD4)));
      reply_q.push_back(8'hD5);
      reply_q.push_back((mode == 3) ? 8'(el + 1) : 8'(el));
      foreach (exp_pl[i]) pl.push_back(exp_pl[i]);
      if (mode == 1) begin
        cut = $urandom_range(0, el - 1);
        pl[cut] = pl[cut] ^ 8'($urandom_range(1, 255));
      end
      c = 8'h00;
      foreach (pl[i]) begin c = crc8(c, pl[i]);  reply_q.push_back(pl[i]); end
      if (mode == 2) c = c ^ (8'h01 << $urandom_range(0, 7));
      reply_q.push_back(c);
      if (mode == 5) repeat ($urandom_range(1, reply_q.size())) void'(reply_q.pop_back());
      run_txn(tl, el, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/s3g_link_tester.md
# s3g_link_tester

Self-checking S3G link exerciser for on-board bring-up and regression of the host UART path. It sits beside `uart_transceiver` in place of a host. It frames a host-loaded payload as an S3G packet and transmits it byte by byte. It then waits for the reply packet and checks its length, payload and CRC against host-loaded expected bytes, within a timeout. The block is a synthesizable, parametrised successor to the packet-sending and byte-checking logic of the top-level bench, with resync, timeout and pass/fail counting that the bench does not have.

## Interface
- `MAX_PAYLOAD`, 32: depth of each payload RAM; legal lengths are 1..MAX_PAYLOAD (≤255).
- `TIMEOUT`, 100000: maximum clk cycles allowed between received bytes, and before the first received byte.
- `GAP`, 0: idle clk cycles inserted after each `tx_done` before the next `tx_wr`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tx_len` in 8: number of payload bytes to send; sampled on `start`.
- `tx_we` in 1: write strobe for the transmit payload RAM.
- `tx_addr` in clog2(MAX_PAYLOAD): address for transmit payload RAM writes.
- `tx_wdata` in 8: data for transmit payload RAM writes.
- `exp_len` in 8: expected reply payload length; sampled on `start`.
- `exp_we` in 1: write strobe for the expected payload RAM.
- `exp_addr` in clog2(MAX_PAYLOAD): address for expected payload RAM writes.
- `exp_wdata` in 8: data for expected payload RAM writes.
- `start` in 1: one-cycle pulse that starts a transaction; ignored unless idle.
- `uart_tx_data` out 8: byte to the UART transmitter.
- `uart_tx_wr` out 1: one-cycle write pulse to the UART transmitter.
- `uart_tx_done` in 1: one-cycle pulse when the UART transmitter has finished a byte.
- `uart_rx_data` in 8: received byte.
- `uart_rx_done` in 1: one-cycle pulse when `uart_rx_data` is valid.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when a transaction ends.
- `pass` out 1: result of the last transaction; held until the next `start`.
- `fail_code` out 3: 0 = none, 1 = timeout, 2 = length mismatch, 3 = data mismatch, 4 = CRC mismatch, 5 = bad parameter.
- `fail_index` out 8: payload index of the first data mismatch.
- `pkt_count` out 16: number of completed transactions.
- `err_count` out 16: number of failed transactions.

## Operation
- CRC is CRC-8/Maxim (reflected polynomial 0x8C, init 0x00, no final xor). It covers payload bytes only, not 0xD5 or the length byte.
- States are IDLE, TX_SOF, TX_LEN, TX_DATA, TX_CRC, RX_SOF, RX_LEN, RX_DATA, RX_CRC, FINISH.
- IDLE → TX_SOF on `start`.
  - `busy` rises, `pass` is cleared, `fail_code` is cleared and the CRC is cleared.
  - If `tx_len` or `exp_len` is 0 or greater than MAX_PAYLOAD, go straight to FINISH with code 5; no bytes are sent.
- TX states send, in order: 0xD5, `tx_len`, the payload from RAM index 0 upward, then the CRC.
  - Each byte is one `uart_tx_wr` pulse. The next pulse waits for `uart_tx_done` plus GAP cycles.
  - The timeout counter is cleared on entry to RX_SOF.
- RX_SOF drops every byte other than 0xD5 (resync).
- RX_LEN: if the length ≠ `exp_len`, fail code 2 → FINISH immediately.
- RX_DATA accumulates the CRC.
  - The first mismatch against the expected RAM latches `fail_index` and code 3.
  - On a mismatch the block keeps receiving, to stay aligned.
- RX_CRC: if the CRC mismatches and no data error was latched, code 4.
- Any `uart_rx_done` arriving during TX states is ignored.
- The timeout counter reloads on every `uart_rx_done` in RX states. If it reaches TIMEOUT, code 1 → FINISH.
- FINISH: `done` pulses for one cycle, `pass` = (code == 0), `pkt_count` increments, and `err_count` increments on failure → IDLE.
- Counters wrap modulo 2^16.
- RAMs are writable at any time. Writes during `busy` take effect for bytes not yet read (no protection).

## Timing
- Reset values: `uart_tx_data` = 0, `uart_tx_wr` = 0, `busy` = 0, `done` = 0, `pass` = 0, `fail_code` = 0, `fail_index` = 0, `pkt_count` = 0, `err_count` = 0; state IDLE. RAM contents are not reset.
- First `uart_tx_wr` comes 1 cycle after the `start` cycle.
- Transmit pacing: `uart_tx_wr` follows `uart_tx_done` by GAP+1 cycles.
- A `uart_rx_done` that coincides with the timeout-terminal cycle counts as received; no timeout is declared.
- `done` comes 1 cycle after the cycle in which the CRC byte is received, or 1 cycle after the failing event.
- `start` while `busy` is ignored.
- `rst` mid-transaction aborts on the next edge. No further `uart_tx_wr` is issued and counters are cleared.

## Test plan
- Transmit payload {00}, expected {85}; bench replies D5 01 85 B3 → TX bytes D5 01 00 00, `pass` = 1, `fail_code` = 0, `pkt_count` = 1.
- Same transaction, reply CRC B4 → `pass` = 0, `fail_code` = 4, `err_count` = 1.
- Reply FF 12 D5 01 85 B3 → resync on D5, `pass` = 1.
- Expected {86}, reply D5 01 85 B3 → `fail_code` = 3, `fail_index` = 0. Reply length 02 → `fail_code` = 2.
- No reply, TIMEOUT = 50 → `done` exactly 51 cycles after the last `uart_tx_done`, `fail_code` = 1. Also: `tx_len` = 0 → `fail_code` = 5 and no `uart_tx_wr`.
- `rst` asserted while TX_DATA is waiting for `uart_tx_done` → all outputs reach their reset values next cycle, and no `uart_tx_wr` follows the pending `uart_tx_done`.
